// File: rtl/count_uart_pkg.sv
// Shared types and frame-length constants for the counter-to-UART transmitter.
// COUNT_UART_PARITY_EN selects the frame format with an even-parity bit.
package count_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Bits added around the data word: start + stop, plus parity when enabled.
    localparam int FRAME_OVERHEAD_PLAIN  = 2;
    localparam int FRAME_OVERHEAD_PARITY = 3;

`ifdef COUNT_UART_PARITY_EN
    localparam int FRAME_OVERHEAD = FRAME_OVERHEAD_PARITY;
`else
    localparam int FRAME_OVERHEAD = FRAME_OVERHEAD_PLAIN;
`endif

    function automatic int frame_bits(input int data_w);
        return data_w + FRAME_OVERHEAD;
    endfunction

endpackage

// File: rtl/count_uart_baud.sv
// Bit-period counter: loads the divider, counts down, and flags the last
// cycle of each bit period when it reaches zero.
module count_uart_baud #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/count_uart_tx.sv
// Serialises words from the upstream counter onto a UART line, LSB first.
// Define COUNT_UART_PARITY_EN to append an even-parity bit before the stop bit.
module count_uart_tx
    import count_uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic [DIV_W-1:0]  baud_div,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] shreg;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DIV_W-1:0]  div_q;
    logic              out_of_reset;
    logic              accept;
    logic              bit_tick;
    logic              last_bit;
    logic              baud_load;
`ifdef COUNT_UART_PARITY_EN
    logic              par_q;
`endif

    // data_ready stays low during reset even though the state already reads IDLE.
    assign data_ready = out_of_reset && (state == IDLE) && ena;
    assign accept     = data_ready && data_valid;
    assign busy       = (state != IDLE);
    assign last_bit   = (bit_cnt == LAST_BIT);
    assign baud_load  = accept || (busy && bit_tick);

    count_uart_baud #(
        .DIV_W(DIV_W)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (baud_load),
        .load_val(accept ? baud_div : div_q),
        .tick    (bit_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            out_of_reset <= 1'b0;
        end else begin
            state        <= state_nxt;
            out_of_reset <= 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        tx         = 1'b1;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = START;
            end
            START: begin
                tx = 1'b0;
                if (bit_tick) state_nxt = DATA;
            end
            DATA: begin
                tx = shreg[0];
                if (bit_tick && last_bit) begin
`ifdef COUNT_UART_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
            PARITY: begin
`ifdef COUNT_UART_PARITY_EN
                tx = par_q;
`endif
                if (bit_tick) state_nxt = STOP;
            end
            STOP: begin
                if (bit_tick) begin
                    frame_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame inputs are captured once at acceptance so the frame ignores later changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
            div_q   <= '0;
`ifdef COUNT_UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else if (accept) begin
            shreg   <= data_in;
            bit_cnt <= '0;
            div_q   <= baud_div;
`ifdef COUNT_UART_PARITY_EN
            par_q   <= ^data_in;
`endif
        end else if (state == DATA && bit_tick) begin
            shreg   <= shreg >> 1;
            bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_count_uart_tx.sv
// Directed self-checking bench for count_uart_tx (both parity settings).
module tb_count_uart_tx;

`ifdef COUNT_UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] data_in = '0;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic [7:0] baud_div = '0;
    logic       tx;
    logic       busy;
    logic       frame_done;

    int total = 0;
    int bad = 0;

    count_uart_tx #(.DATA_W(8), .DIV_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .data_in   (data_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .baud_div  (baud_div),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame vector bit 0 is the start bit; cycle k (1-based) falls in bit (k-1)/(div+1).
    function automatic logic exp_tx(input logic [10:0] f, input int k, input int div);
        return f[(k-1)/(div+1)];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; data_valid = 1'b0;
        #1;
        total++; if (data_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready got=%b want=0", data_ready); end
        total++; if (tx !== 1'b1) begin bad++; $display("[TB] FAIL reset_tx got=%b want=1", tx); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        total++; if (data_ready !== 1'b1) begin bad++; $display("[TB] FAIL idle_ready got=%b want=1", data_ready); end
        total++; if (tx !== 1'b1) begin bad++; $display("[TB] FAIL idle_tx got=%b want=1", tx); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL idle_busy got=%b want=0", busy); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("[TB] FAIL idle_done got=%b want=0", frame_done); end
    endtask

    task automatic test_single_frame();
        logic [10:0] f;
        int len;
`ifdef COUNT_UART_PARITY_EN
        f = 11'b1_0_10100101_0;
`else
        f = 11'b0_1_10100101_0;
`endif
        len = NB * 4;
        data_in = 8'hA5; baud_div = 8'd3; data_valid = 1'b1;
        tick();
        data_valid = 1'b0; data_in = 8'hFF; baud_div = 8'd0;
        for (int k = 1; k <= len; k++) begin
            total++; if (tx !== exp_tx(f, k, 3)) begin bad++; $display("[TB] FAIL single_tx cyc=%0d got=%b want=%b", k, tx, exp_tx(f, k, 3)); end
            total++; if (frame_done !== (k == len)) begin bad++; $display("[TB] FAIL single_done cyc=%0d got=%b want=%b", k, frame_done, k == len); end
            total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL single_busy cyc=%0d got=%b want=1", k, busy); end
            total++; if (data_ready !== 1'b0) begin bad++; $display("[TB] FAIL single_ready cyc=%0d got=%b want=0", k, data_ready); end
            tick();
        end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL single_end_busy got=%b want=0", busy); end
        total++; if (tx !== 1'b1) begin bad++; $display("[TB] FAIL single_end_tx got=%b want=1", tx); end
    endtask

    task automatic test_parity();
        logic [10:0] f;
`ifdef COUNT_UART_PARITY_EN
        f = 11'b1_1_00000111_0;
`else
        f = 11'b0_1_00000111_0;
`endif
        data_in = 8'h07; baud_div = 8'd0; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        for (int k = 1; k <= NB; k++) begin
            total++; if (tx !== f[k-1]) begin bad++; $display("[TB] FAIL parity_tx cyc=%0d got=%b want=%b", k, tx, f[k-1]); end
            total++; if (frame_done !== (k == NB)) begin bad++; $display("[TB] FAIL parity_done cyc=%0d got=%b want=%b", k, frame_done, k == NB); end
            tick();
        end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL parity_end_busy got=%b want=0", busy); end
    endtask

    task automatic test_reset_mid_frame();
        data_in = 8'hA5; baud_div = 8'd3; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        repeat (17) tick();
        total++; if (tx !== 1'b0) begin bad++; $display("[TB] FAIL midrst_bit3 got=%b want=0", tx); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (tx !== 1'b1) begin bad++; $display("[TB] FAIL midrst_tx got=%b want=1", tx); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy got=%b want=0", busy); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("[TB] FAIL midrst_done got=%b want=0", frame_done); end
        total++; if (data_ready !== 1'b0) begin bad++; $display("[TB] FAIL midrst_ready got=%b want=0", data_ready); end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            total++; if (frame_done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) begin
                bad++; $display("[TB] FAIL midrst_after cyc=%0d got done=%b busy=%b tx=%b want 0/0/1", k, frame_done, busy, tx);
            end
        end
        total++; if (data_ready !== 1'b1) begin bad++; $display("[TB] FAIL midrst_ready_after got=%b want=1", data_ready); end
    endtask

    task automatic test_back_to_back();
        logic [10:0] f1, f2;
        int ready_cnt;
`ifdef COUNT_UART_PARITY_EN
        f1 = 11'b1_1_00000001_0;
        f2 = 11'b1_1_00000010_0;
`else
        f1 = 11'b0_1_00000001_0;
        f2 = 11'b0_1_00000010_0;
`endif
        ready_cnt = 0;
        data_in = 8'h01; baud_div = 8'd0; data_valid = 1'b1;
        #1;
        if (data_ready === 1'b1) ready_cnt++;
        tick();
        data_in = 8'h02;
        for (int k = 1; k <= NB; k++) begin
            total++; if (tx !== f1[k-1]) begin bad++; $display("[TB] FAIL b2b_f1_tx cyc=%0d got=%b want=%b", k, tx, f1[k-1]); end
            if (data_ready === 1'b1) ready_cnt++;
            tick();
        end
        total++; if (tx !== 1'b1 || busy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_gap got tx=%b busy=%b want 1/0", tx, busy); end
        if (data_ready === 1'b1) ready_cnt++;
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_second_start got busy=%b want=1", busy); end
        data_valid = 1'b0;
        for (int k = 1; k <= NB; k++) begin
            total++; if (tx !== f2[k-1]) begin bad++; $display("[TB] FAIL b2b_f2_tx cyc=%0d got=%b want=%b", k, tx, f2[k-1]); end
            if (data_ready === 1'b1) ready_cnt++;
            tick();
        end
        total++; if (ready_cnt !== 2) begin bad++; $display("[TB] FAIL b2b_ready_cycles got=%0d want=2", ready_cnt); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_end_busy got=%b want=0", busy); end
    endtask

    task automatic test_ena_drop();
        logic [10:0] f1, f2;
        int len;
`ifdef COUNT_UART_PARITY_EN
        f1 = 11'b1_0_00111100_0;
        f2 = 11'b1_0_11111111_0;
`else
        f1 = 11'b0_1_00111100_0;
        f2 = 11'b0_1_11111111_0;
`endif
        len = NB * 2;
        ena = 1'b1; data_in = 8'h3C; baud_div = 8'd1; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        for (int k = 1; k <= len; k++) begin
            if (k == 5) begin
                ena = 1'b0; data_in = 8'hFF; data_valid = 1'b1;
            end
            total++; if (tx !== exp_tx(f1, k, 1)) begin bad++; $display("[TB] FAIL ena_tx cyc=%0d got=%b want=%b", k, tx, exp_tx(f1, k, 1)); end
            total++; if (frame_done !== (k == len)) begin bad++; $display("[TB] FAIL ena_done cyc=%0d got=%b want=%b", k, frame_done, k == len); end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            total++; if (busy !== 1'b0 || data_ready !== 1'b0 || tx !== 1'b1) begin
                bad++; $display("[TB] FAIL ena_hold cyc=%0d got busy=%b ready=%b tx=%b want 0/0/1", k, busy, data_ready, tx);
            end
            tick();
        end
        ena = 1'b1;
        #1;
        total++; if (data_ready !== 1'b1) begin bad++; $display("[TB] FAIL ena_restore_ready got=%b want=1", data_ready); end
        tick();
        data_valid = 1'b0;
        for (int k = 1; k <= len; k++) begin
            total++; if (tx !== exp_tx(f2, k, 1)) begin bad++; $display("[TB] FAIL ena_f2_tx cyc=%0d got=%b want=%b", k, tx, exp_tx(f2, k, 1)); end
            tick();
        end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL ena_end_busy got=%b want=0", busy); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_parity();
        test_reset_mid_frame();
        test_back_to_back();
        test_ena_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/count_uart_tx.md
COUNT_UART_TX -- requirements
Module: count_uart_tx

Interface
REQ-001 Parameter DATA_W, default 8, width of the data word taken from the upstream counter stage.
REQ-002 Parameter DIV_W, default 8, width of the baud divider input.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ena  input  1  block enable; low blocks new word acceptance only.
REQ-006 data_in  input  DATA_W  word from the upstream counter output.
REQ-007 data_valid  input  1  upstream asserts when data_in holds a word to send.
REQ-008 data_ready  output  1  block can accept a word this cycle.
REQ-009 baud_div  input  DIV_W  clocks per bit minus one.
REQ-010 tx  output  1  serial line, idle high.
REQ-011 busy  output  1  high while a frame is in progress.
REQ-012 frame_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Function
REQ-013 The block SHALL use the states IDLE, START, DATA, PARITY and STOP.
REQ-014 data_ready SHALL be 1 only in IDLE with ena=1.
REQ-015 A word SHALL be accepted on a cycle with data_valid=1 and data_ready=1; data_in and baud_div are captured in that cycle.
REQ-016 The next state after acceptance SHALL be START; tx SHALL go low on the cycle after acceptance (one cycle latency).
REQ-017 Each bit SHALL last exactly captured baud_div+1 cycles; baud_div=0 gives 1 cycle per bit, and all-ones gives 2^DIV_W cycles.
REQ-018 Data bits SHALL be sent LSB first, DATA_W bits, with the bit counter wrapping to 0 when it leaves DATA.
REQ-019 STOP SHALL drive tx=1 for one bit period, then return to IDLE; frame_done pulses in the final STOP cycle.
REQ-020 busy SHALL equal (state != IDLE).
REQ-021 A change to data_in, baud_div or data_valid during a frame SHALL NOT affect that frame.
REQ-022 ena deasserted during a frame SHALL NOT stop it; the frame completes, and no new word is accepted until ena=1.
REQ-023 Back-to-back: if data_valid=1 in the cycle after frame_done, the word SHALL be accepted in that cycle, so at least one IDLE cycle (tx=1) separates frames.
REQ-024 data_valid=1 with ena=0 in IDLE SHALL leave the block in IDLE with data_ready=0.

Reset
REQ-025 rst_n low SHALL immediately force state=IDLE, tx=1, busy=0, frame_done=0, and clear the shift register, bit counter and baud counter.
REQ-026 data_ready SHALL be 0 while rst_n is low, and follow REQ-014 from the first clock edge after release.
REQ-027 Reset in the middle of a frame SHALL abort the frame with no frame_done pulse.

Configuration
REQ-028 With COUNT_UART_PARITY_EN defined, an even-parity bit (XOR of the captured word) SHALL be sent in PARITY between DATA and STOP, one bit period long; a frame is DATA_W+3 bits.
REQ-029 Without COUNT_UART_PARITY_EN, PARITY SHALL be unreachable, DATA SHALL go directly to STOP, and a frame is DATA_W+2 bits.

Structure
REQ-030 Package count_uart_pkg SHALL hold the state enum typedef and the frame-length constants for both macro settings.
REQ-031 Sub-module count_uart_baud (baud counter: load, count down, tick at zero) SHALL produce the bit-period tick.
REQ-032 The FSM, shift register and bit counter SHALL reside in count_uart_tx.

Verification
REQ-033 Reset then idle: rst_n=0 for 3 cycles, then release -> tx=1, busy=0, data_ready=1 (with ena=1).
REQ-034 Single frame: data_in=8'hA5, baud_div=3, valid for 1 cycle -> tx low for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, stop high 4 cycles, frame_done on frame cycle 40 (parity off).
REQ-035 Parity on: data_in=8'h07, baud_div=0 -> bits 0,1,1,1,0,0,0,0,0, parity=1, stop=1, and frame_done on cycle 11.
REQ-036 Reset mid-frame: assert rst_n=0 during data bit 3 -> tx=1 in the same cycle, no frame_done, IDLE after release.
REQ-037 Handshake: hold data_valid=1 with 8'h01 then 8'h02 -> two frames with exactly one tx=1 idle cycle between them; data_ready is high for exactly one cycle each time.
REQ-038 ena drop: ena=0 during DATA -> frame completes normally; a pending data_valid is not accepted until ena=1.
